axi_tdd_ng_profile_sched: RTL and testbench



---
 rtl/axi_tdd_ng_pkg.sv | 11 +
 rtl/axi_tdd_ng_profile_table.sv | 48 ++++
 rtl/axi_tdd_ng_profile_sched.sv | 135 +++++++++++++
 tb/tb_axi_tdd_ng_profile_sched.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_tdd_ng_pkg.sv
// Shared types for the TDD engine blocks.
// Holds the profile scheduler state encoding.
package axi_tdd_ng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/axi_tdd_ng_profile_table.sv
// Register-file of frame profiles: one write port, one combinational read port.
// A read in the cycle of a write to the same slot returns the old contents.
module axi_tdd_ng_profile_table
  import axi_tdd_ng_pkg::*;
#(
  parameter int PROFILE_COUNT  = 4,
  parameter int CHANNEL_COUNT  = 8,
  parameter int REGISTER_WIDTH = 32,
  parameter int REPEAT_WIDTH   = 16,
  localparam int IDX_W         = $clog2(PROFILE_COUNT)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      wr,
  input  logic [IDX_W-1:0]          wr_addr,
  input  logic [REGISTER_WIDTH-1:0] wr_frame_length,
  input  logic [CHANNEL_COUNT-1:0]  wr_channel_en,
  input  logic [REPEAT_WIDTH-1:0]   wr_repeat,
  input  logic [IDX_W-1:0]          rd_addr,
  output logic [REGISTER_WIDTH-1:0] rd_frame_length,
  output logic [CHANNEL_COUNT-1:0]  rd_channel_en,
  output logic [REPEAT_WIDTH-1:0]   rd_repeat
);

  logic [REGISTER_WIDTH-1:0] len_mem [PROFILE_COUNT];
  logic [CHANNEL_COUNT-1:0]  en_mem  [PROFILE_COUNT];
  logic [REPEAT_WIDTH-1:0]   rep_mem [PROFILE_COUNT];

  // Writes to addresses beyond the table are dropped for non-power-of-two sizes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < PROFILE_COUNT; i++) begin
        len_mem[i] <= '0;
        en_mem[i]  <= '0;
        rep_mem[i] <= '0;
      end
    end else if (wr && (int'(wr_addr) < PROFILE_COUNT)) begin
      len_mem[wr_addr] <= wr_frame_length;
      en_mem[wr_addr]  <= wr_channel_en;
      rep_mem[wr_addr] <= wr_repeat;
    end
  end

  assign rd_frame_length = len_mem[rd_addr];
  assign rd_channel_en   = en_mem[rd_addr];
  assign rd_repeat       = rep_mem[rd_addr];

endmodule

// File: rtl/axi_tdd_ng_profile_sched.sv
// Frame-profile scheduler: walks the profile table at frame boundaries and
// drives the active frame length and channel mask from shadow registers.
module axi_tdd_ng_profile_sched
  import axi_tdd_ng_pkg::*;
#(
  parameter int PROFILE_COUNT  = 4,
  parameter int CHANNEL_COUNT  = 8,
  parameter int REGISTER_WIDTH = 32,
  parameter int REPEAT_WIDTH   = 16,
  localparam int IDX_W         = $clog2(PROFILE_COUNT)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      tdd_enable,
  input  logic                      tdd_endof_frame,
  input  logic                      cfg_wr,
  input  logic [IDX_W-1:0]          cfg_addr,
  input  logic [REGISTER_WIDTH-1:0] cfg_frame_length,
  input  logic [CHANNEL_COUNT-1:0]  cfg_channel_en,
  input  logic [REPEAT_WIDTH-1:0]   cfg_repeat,
  input  logic [IDX_W-1:0]          cfg_last,
  input  logic                      cfg_loop,
  output logic [REGISTER_WIDTH-1:0] tdd_frame_length,
  output logic [CHANNEL_COUNT-1:0]  tdd_channel_en,
  output logic [IDX_W-1:0]          sched_profile,
  output logic                      sched_active,
  output logic                      sched_done
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(PROFILE_COUNT - 1);

  sched_state_t              state;
  logic                      enable_q;
  logic [REPEAT_WIDTH-1:0]   frame_cnt;
  logic [REPEAT_WIDTH-1:0]   cur_repeat;
  logic [REPEAT_WIDTH-1:0]   repeat_eff;
  logic [IDX_W-1:0]          last_eff;
  logic [IDX_W-1:0]          next_slot;
  logic                      more_frames;
  logic [REGISTER_WIDTH-1:0] rd_frame_length;
  logic [CHANNEL_COUNT-1:0]  rd_channel_en;
  logic [REPEAT_WIDTH-1:0]   rd_repeat;

  axi_tdd_ng_profile_table #(
    .PROFILE_COUNT  (PROFILE_COUNT),
    .CHANNEL_COUNT  (CHANNEL_COUNT),
    .REGISTER_WIDTH (REGISTER_WIDTH),
    .REPEAT_WIDTH   (REPEAT_WIDTH)
  ) i_table (
    .clk             (clk),
    .resetn          (resetn),
    .wr              (cfg_wr),
    .wr_addr         (cfg_addr),
    .wr_frame_length (cfg_frame_length),
    .wr_channel_en   (cfg_channel_en),
    .wr_repeat       (cfg_repeat),
    .rd_addr         (next_slot),
    .rd_frame_length (rd_frame_length),
    .rd_channel_en   (rd_channel_en),
    .rd_repeat       (rd_repeat)
  );

  // The read port always points at the slot the next load would take.
  always_comb begin
    last_eff    = (int'(cfg_last) > PROFILE_COUNT - 1) ? MAX_IDX : cfg_last;
    repeat_eff  = (cur_repeat == '0) ? REPEAT_WIDTH'(1) : cur_repeat;
    more_frames = frame_cnt < (repeat_eff - REPEAT_WIDTH'(1));
    next_slot   = '0;
    if (state == RUN && sched_profile != last_eff) begin
      next_slot = sched_profile + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state            <= IDLE;
      enable_q         <= 1'b0;
      frame_cnt        <= '0;
      cur_repeat       <= '0;
      tdd_frame_length <= '0;
      tdd_channel_en   <= '0;
      sched_profile    <= '0;
      sched_active     <= 1'b0;
      sched_done       <= 1'b0;
    end else begin
      enable_q   <= tdd_enable;
      sched_done <= 1'b0;
      if (!tdd_enable) begin
        state            <= IDLE;
        frame_cnt        <= '0;
        cur_repeat       <= '0;
        tdd_frame_length <= '0;
        tdd_channel_en   <= '0;
        sched_profile    <= '0;
        sched_active     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!enable_q) begin
              state            <= RUN;
              frame_cnt        <= '0;
              cur_repeat       <= rd_repeat;
              tdd_frame_length <= rd_frame_length;
              tdd_channel_en   <= rd_channel_en;
              sched_profile    <= next_slot;
              sched_active     <= 1'b1;
            end
          end
          RUN: begin
            if (tdd_endof_frame) begin
              if (more_frames) begin
                frame_cnt <= frame_cnt + REPEAT_WIDTH'(1);
              end else if (sched_profile != last_eff || cfg_loop) begin
                frame_cnt        <= '0;
                cur_repeat       <= rd_repeat;
                tdd_frame_length <= rd_frame_length;
                tdd_channel_en   <= rd_channel_en;
                sched_profile    <= next_slot;
              end else begin
                state          <= DONE;
                tdd_channel_en <= '0;
                sched_active   <= 1'b0;
                sched_done     <= 1'b1;
              end
            end
          end
          default: begin
            state <= DONE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_tdd_ng_profile_sched.sv
// Scoreboard bench for the profile scheduler: each scenario queues per-cycle
// stimulus with the outputs expected after that edge and drains it against the DUT.
module tb_axi_tdd_ng_profile_sched;

  typedef struct packed {
    logic rstn;
    logic en;
    logic eof;
    logic wr;
    logic loop;
  } stim_t;

  typedef struct packed {
    logic [1:0]  prof;
    logic [31:0] len;
    logic [7:0]  en;
    logic        act;
    logic        done;
  } exp_t;

  localparam exp_t ZERO = '0;
  localparam exp_t S0   = '{2'd0, 32'd10, 8'h01, 1'b1, 1'b0};
  localparam exp_t S1   = '{2'd1, 32'd20, 8'h02, 1'b1, 1'b0};
  localparam exp_t S2   = '{2'd2, 32'd30, 8'h04, 1'b1, 1'b0};
  localparam exp_t S3   = '{2'd3, 32'd40, 8'h08, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        resetn;
  logic        tdd_enable;
  logic        tdd_endof_frame;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_frame_length;
  logic [7:0]  cfg_channel_en;
  logic [15:0] cfg_repeat;
  logic [1:0]  cfg_last;
  logic        cfg_loop;
  logic [31:0] tdd_frame_length;
  logic [7:0]  tdd_channel_en;
  logic [1:0]  sched_profile;
  logic        sched_active;
  logic        sched_done;

  int checks = 0;
  int errors = 0;
  stim_t stim_q[$];
  exp_t  exp_q[$];

  axi_tdd_ng_profile_sched dut (
    .clk              (clk),
    .resetn           (resetn),
    .tdd_enable       (tdd_enable),
    .tdd_endof_frame  (tdd_endof_frame),
    .cfg_wr           (cfg_wr),
    .cfg_addr         (cfg_addr),
    .cfg_frame_length (cfg_frame_length),
    .cfg_channel_en   (cfg_channel_en),
    .cfg_repeat       (cfg_repeat),
    .cfg_last         (cfg_last),
    .cfg_loop         (cfg_loop),
    .tdd_frame_length (tdd_frame_length),
    .tdd_channel_en   (tdd_channel_en),
    .sched_profile    (sched_profile),
    .sched_active     (sched_active),
    .sched_done       (sched_done)
  );

  always #5 clk = ~clk;

  function automatic exp_t observe();
    return '{sched_profile, tdd_frame_length, tdd_channel_en, sched_active, sched_done};
  endfunction

  task automatic plan(input logic rstn, input logic en, input logic eof,
                      input logic wr, input logic loop, input exp_t e);
    stim_q.push_back('{rstn, en, eof, wr, loop});
    exp_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    resetn          = s.rstn;
    tdd_enable      = s.en;
    tdd_endof_frame = s.eof;
    cfg_wr          = s.wr;
    cfg_loop        = s.loop;
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input logic [1:0] a, input logic [31:0] l,
                            input logic [7:0] e, input logic [15:0] r);
    cfg_wr           = 1'b1;
    cfg_addr         = a;
    cfg_frame_length = l;
    cfg_channel_en   = e;
    cfg_repeat       = r;
    @(posedge clk);
    #1;
    cfg_wr = 1'b0;
  endtask

  task automatic program_std();
    write_slot(2'd0, 32'd10, 8'h01, 16'd2);
    write_slot(2'd1, 32'd20, 8'h02, 16'd1);
    write_slot(2'd2, 32'd30, 8'h04, 16'd3);
    cfg_last = 2'd2;
  endtask

  task automatic test_reset();
    exp_t e, g;
    int step = 0;
    plan(0, 0, 0, 0, 0, ZERO);
    plan(0, 1, 1, 0, 0, ZERO);
    plan(1, 0, 1, 0, 0, ZERO);
    plan(1, 0, 0, 0, 0, ZERO);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      g = observe();
      checks++;
      if (g !== e) begin
        errors++;
        $display("[TB] FAIL reset step %0d: got %h required %h", step, g, e);
      end
      step++;
    end
  endtask

  task automatic test_single_pass();
    exp_t e, g;
    int step = 0;
    program_std();
    plan(1, 1, 0, 0, 0, S0);
    plan(1, 1, 1, 0, 0, S0);
    plan(1, 1, 0, 0, 0, S0);
    plan(1, 1, 1, 0, 0, S1);
    plan(1, 1, 1, 0, 0, S2);
    plan(1, 1, 1, 0, 0, S2);
    plan(1, 1, 1, 0, 0, S2);
    plan(1, 1, 0, 0, 0, S2);
    plan(1, 1, 1, 0, 0, '{2'd2, 32'd30, 8'h00, 1'b0, 1'b1});
    plan(1, 1, 0, 0, 0, '{2'd2, 32'd30, 8'h00, 1'b0, 1'b0});
    plan(1, 1, 1, 0, 0, '{2'd2, 32'd30, 8'h00, 1'b0, 1'b0});
    plan(1, 0, 0, 0, 0, ZERO);
    plan(1, 1, 0, 0, 0, S0);
    plan(1, 0, 0, 0, 0, ZERO);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      g = observe();
      checks++;
      if (g !== e) begin
        errors++;
        $display("[TB] FAIL single_pass step %0d: got %h required %h", step, g, e);
      end
      step++;
    end
  endtask

  task automatic test_loop();
    exp_t e, g;
    int step = 0;
    program_std();
    plan(1, 1, 0, 0, 1, S0);
    for (int i = 0; i < 8; i++) begin
      plan(1, 1, 1, 0, 1, (i == 0 || i == 5 || i == 6) ? S0 : (i == 1 || i == 7) ? S1 : S2);
    end
    plan(1, 0, 0, 0, 1, ZERO);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      g = observe();
      checks++;
      if (g !== e) begin
        errors++;
        $display("[TB] FAIL loop step %0d: got %h required %h", step, g, e);
      end
      step++;
    end
  endtask

  task automatic test_repeat_zero();
    exp_t e, g;
    int step = 0;
    program_std();
    write_slot(2'd0, 32'd10, 8'h01, 16'd0);
    plan(1, 1, 0, 0, 0, S0);
    plan(1, 1, 1, 0, 0, S1);
    plan(1, 1, 1, 0, 0, S2);
    plan(1, 0, 0, 0, 0, ZERO);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      g = observe();
      checks++;
      if (g !== e) begin
        errors++;
        $display("[TB] FAIL repeat_zero step %0d: got %h required %h", step, g, e);
      end
      step++;
    end
  endtask

  task automatic test_read_before_write();
    exp_t e, g;
    int step = 0;
    program_std();
    cfg_addr         = 2'd1;
    cfg_frame_length = 32'd99;
    cfg_channel_en   = 8'hFF;
    cfg_repeat       = 16'd1;
    plan(1, 1, 0, 0, 1, S0);
    plan(1, 1, 1, 0, 1, S0);
    plan(1, 1, 1, 1, 1, S1);
    plan(1, 1, 0, 0, 1, S1);
    plan(1, 1, 1, 0, 1, S2);
    plan(1, 1, 1, 0, 1, S2);
    plan(1, 1, 1, 0, 1, S2);
    plan(1, 1, 1, 0, 1, S0);
    plan(1, 1, 1, 0, 1, S0);
    plan(1, 1, 1, 0, 1, '{2'd1, 32'd99, 8'hFF, 1'b1, 1'b0});
    plan(1, 0, 0, 0, 1, ZERO);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      g = observe();
      checks++;
      if (g !== e) begin
        errors++;
        $display("[TB] FAIL read_before_write step %0d: got %h required %h", step, g, e);
      end
      step++;
    end
  endtask

  task automatic test_disable_and_reset();
    exp_t e, g;
    int step = 0;
    program_std();
    plan(1, 1, 0, 0, 0, S0);
    plan(1, 1, 1, 0, 0, S0);
    plan(1, 1, 1, 0, 0, S1);
    plan(1, 0, 1, 0, 0, ZERO);
    plan(1, 1, 0, 0, 0, S0);
    plan(1, 1, 1, 0, 0, S0);
    plan(1, 1, 1, 0, 0, S1);
    plan(0, 1, 1, 0, 0, ZERO);
    plan(1, 0, 0, 0, 0, ZERO);
    plan(1, 1, 0, 0, 0, '{2'd0, 32'd0, 8'h00, 1'b1, 1'b0});
    plan(1, 0, 0, 0, 0, ZERO);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      g = observe();
      checks++;
      if (g !== e) begin
        errors++;
        $display("[TB] FAIL disable_reset step %0d: got %h required %h", step, g, e);
      end
      step++;
    end
  endtask

  task automatic test_last_clamp();
    exp_t e, g;
    logic [2:0] seven;
    int step = 0;
    program_std();
    write_slot(2'd3, 32'd40, 8'h08, 16'd1);
    seven    = 3'd7;
    cfg_last = seven[1:0];
    plan(1, 1, 0, 0, 1, S0);
    plan(1, 1, 1, 0, 1, S0);
    plan(1, 1, 1, 0, 1, S1);
    plan(1, 1, 1, 0, 1, S2);
    plan(1, 1, 1, 0, 1, S2);
    plan(1, 1, 1, 0, 1, S2);
    plan(1, 1, 1, 0, 1, S3);
    plan(1, 1, 1, 0, 1, S0);
    plan(1, 0, 0, 0, 0, ZERO);
    plan(1, 1, 0, 0, 0, S0);
    plan(1, 1, 1, 0, 0, S0);
    plan(1, 1, 1, 0, 0, S1);
    plan(1, 1, 1, 0, 0, S2);
    plan(1, 1, 1, 0, 0, S2);
    plan(1, 1, 1, 0, 0, S2);
    plan(1, 1, 1, 0, 0, S3);
    plan(1, 1, 1, 0, 0, '{2'd3, 32'd40, 8'h00, 1'b0, 1'b1});
    plan(1, 1, 0, 0, 0, '{2'd3, 32'd40, 8'h00, 1'b0, 1'b0});
    plan(1, 0, 0, 0, 0, ZERO);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      g = observe();
      checks++;
      if (g !== e) begin
        errors++;
        $display("[TB] FAIL last_clamp step %0d: got %h required %h", step, g, e);
      end
      step++;
    end
  endtask

  initial begin
    resetn           = 1'b0;
    tdd_enable       = 1'b0;
    tdd_endof_frame  = 1'b0;
    cfg_wr           = 1'b0;
    cfg_addr         = '0;
    cfg_frame_length = '0;
    cfg_channel_en   = '0;
    cfg_repeat       = '0;
    cfg_last         = '0;
    cfg_loop         = 1'b0;
    test_reset();
    test_single_pass();
    test_loop();
    test_repeat_zero();
    test_read_before_write();
    test_disable_and_reset();
    test_last_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
